// File: rtl/audio_mixer_pkg.sv
// Shared FSM encodings, gain format constants and a signed saturation helper
// for the N-channel audio mixer.
package audio_mixer_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ACCUM = 2'd1;
   localparam logic [1:0] SAT   = 2'd2;

   localparam int unsigned GAIN_W    = 4;
   localparam int unsigned GAIN_FRAC = 3;
   localparam int unsigned DCRM_K    = 10;

   // Clamp a wide signed value into the range of a signed 'width'-bit number.
   function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                     input int unsigned        width);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (value > hi) begin
         return hi;
      end else if (value < lo) begin
         return lo;
      end else begin
         return value;
      end
   endfunction

endpackage

// File: rtl/audio_mixer_dcrm.sv
// First-order DC blocker on the mixed output; only instantiated when
// AUDIO_MIXER_DCRM_EN is defined. Adds one cycle of latency.
module audio_mixer_dcrm
   import audio_mixer_pkg::*;
#(
   parameter int unsigned OW = 16
) (
   input  logic                 clk_49m,
   input  logic                 reset,
   input  logic signed [OW-1:0] x,
   input  logic                 x_valid,
   output logic signed [OW-1:0] y,
   output logic                 y_valid
);

   localparam int unsigned DW = OW + 2;

   logic signed [OW-1:0] x_prev_q;
   logic signed [OW-1:0] y_q;
   logic                 valid_q;
   logic signed [DW-1:0] y_next;

   // Two guard bits cover the worst case |x - x_prev| + |y_prev| before saturation.
   always_comb begin
      y_next = DW'(x) - DW'(x_prev_q) + DW'(y_q) - DW'(y_q >>> DCRM_K);
   end

   always_ff @(posedge clk_49m or negedge reset) begin
      if (!reset) begin
         x_prev_q <= '0;
         y_q      <= '0;
         valid_q  <= 1'b0;
      end else begin
         valid_q <= x_valid;
         if (x_valid) begin
            x_prev_q <= x;
            y_q      <= OW'(sat_signed(64'(y_next), OW));
         end
      end
   end

   assign y       = y_q;
   assign y_valid = valid_q;

endmodule

// File: rtl/audio_mixer_nch.sv
// N-channel signed audio mixer: time-multiplexed gain/invert/sum, saturation and
// pause-driven soft mute. Define AUDIO_MIXER_DCRM_EN to add a DC blocker on the output.
module audio_mixer_nch
   import audio_mixer_pkg::*;
#(
   parameter int unsigned NCH  = 4,
   parameter int unsigned IW   = 16,
   parameter int unsigned OW   = 16,
   parameter int unsigned ACCW = 24
) (
   input  logic                     clk_49m,
   input  logic                     reset,
   input  logic                     cen_sample,
   input  logic [NCH*IW-1:0]        ch_in,
   input  logic [NCH*GAIN_W-1:0]    ch_gain,
   input  logic [NCH-1:0]           ch_inv,
   input  logic                     pause,
   output logic signed [OW-1:0]     sound,
   output logic                     sample_valid,
   output logic                     clip,
   output logic                     overrun
);

   localparam int unsigned IDXW = $clog2(NCH);
   localparam int unsigned MSW  = $clog2(OW);
   localparam int unsigned TW   = IW + GAIN_W + 1;
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCH - 1);
   localparam logic [MSW-1:0]  MUTE_MAX = MSW'(OW - 1);

   logic [1:0]             state_q;
   logic [IDXW-1:0]        idx_q;
   logic signed [ACCW-1:0] acc_q;
   logic signed [IW-1:0]   in_q   [NCH];
   logic [GAIN_W-1:0]      gain_q [NCH];
   logic [NCH-1:0]         inv_q;
   logic [MSW-1:0]         mute_sh_q;
   logic signed [OW-1:0]   mix_q;
   logic                   mix_valid_q;
   logic                   clip_q;
   logic                   overrun_q;

   logic signed [IW-1:0]   in_sel;
   logic [GAIN_W-1:0]      gain_sel;
   logic signed [TW-1:0]   prod;
   logic signed [TW-1:0]   term;
   logic signed [TW-1:0]   term_n;
   logic signed [63:0]     acc_wide;
   logic signed [63:0]     sat_full;
   logic signed [OW-1:0]   sat_ow;
   logic signed [OW-1:0]   muted;
   logic                   clamped;

   // Gain is zero-extended to keep it unsigned; the term is negated at full width
   // so the most negative input inverts without wrapping.
   always_comb begin
      in_sel   = in_q[idx_q];
      gain_sel = gain_q[idx_q];
      prod     = TW'(in_sel) * TW'($signed({1'b0, gain_sel}));
      term     = prod >>> GAIN_FRAC;
      term_n   = inv_q[idx_q] ? -term : term;
   end

   always_comb begin
      acc_wide = 64'(acc_q);
      sat_full = sat_signed(acc_wide, OW);
      sat_ow   = sat_full[OW-1:0];
      clamped  = (sat_full != acc_wide);
      muted    = (mute_sh_q >= MUTE_MAX) ? '0 : (sat_ow >>> mute_sh_q);
   end

   always_ff @(posedge clk_49m or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         acc_q       <= '0;
         inv_q       <= '0;
         mute_sh_q   <= '0;
         mix_q       <= '0;
         mix_valid_q <= 1'b0;
         clip_q      <= 1'b0;
         overrun_q   <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            in_q[i]   <= '0;
            gain_q[i] <= '0;
         end
      end else begin
         mix_valid_q <= 1'b0;
         if (cen_sample && (state_q != IDLE)) begin
            overrun_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (cen_sample) begin
                  for (int i = 0; i < NCH; i++) begin
                     in_q[i]   <= ch_in[i*IW +: IW];
                     gain_q[i] <= ch_gain[i*GAIN_W +: GAIN_W];
                  end
                  inv_q   <= ch_inv;
                  acc_q   <= '0;
                  idx_q   <= '0;
                  state_q <= ACCUM;
               end
            end
            ACCUM: begin
               acc_q <= acc_q + ACCW'(term_n);
               if (idx_q == IDX_LAST) begin
                  state_q <= SAT;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            SAT: begin
               mix_q       <= muted;
               mix_valid_q <= 1'b1;
               if (clamped) begin
                  clip_q <= 1'b1;
               end
               // Ramp takes effect from the next sample onward.
               if (pause && (mute_sh_q < MUTE_MAX)) begin
                  mute_sh_q <= mute_sh_q + 1'b1;
               end else if (!pause && (mute_sh_q != '0)) begin
                  mute_sh_q <= mute_sh_q - 1'b1;
               end
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

`ifdef AUDIO_MIXER_DCRM_EN
   audio_mixer_dcrm #(
      .OW(OW)
   ) u_dcrm (
      .clk_49m (clk_49m),
      .reset   (reset),
      .x       (mix_q),
      .x_valid (mix_valid_q),
      .y       (sound),
      .y_valid (sample_valid)
   );
`else
   assign sound        = mix_q;
   assign sample_valid = mix_valid_q;
`endif

   assign clip    = clip_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_audio_mixer_nch.sv
// Directed self-checking bench for audio_mixer_nch (NCH=4, IW=OW=16).
module tb_audio_mixer_nch;

   localparam int NCH = 4;
   localparam int IW  = 16;
   localparam int OW  = 16;
`ifdef AUDIO_MIXER_DCRM_EN
   localparam int LAT = 6;
`else
   localparam int LAT = 5;
`endif

   logic                 clk_49m = 1'b0;
   logic                 reset = 1'b0;
   logic                 cen_sample = 1'b0;
   logic                 pause = 1'b0;
   logic [NCH*IW-1:0]    ch_in = '0;
   logic [NCH*4-1:0]     ch_gain = '0;
   logic [NCH-1:0]       ch_inv = '0;
   logic signed [OW-1:0] sound;
   logic                 sample_valid;
   logic                 clip;
   logic                 overrun;

   int checks = 0;
   int errors = 0;

   always #5 clk_49m = ~clk_49m;

   audio_mixer_nch #(
      .NCH  (NCH),
      .IW   (IW),
      .OW   (OW),
      .ACCW (24)
   ) dut (
      .clk_49m      (clk_49m),
      .reset        (reset),
      .cen_sample   (cen_sample),
      .ch_in        (ch_in),
      .ch_gain      (ch_gain),
      .ch_inv       (ch_inv),
      .pause        (pause),
      .sound        (sound),
      .sample_valid (sample_valid),
      .clip         (clip),
      .overrun      (overrun)
   );

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_ch();
      ch_in   = '0;
      ch_gain = '0;
      ch_inv  = '0;
   endtask

   task automatic set_ch(input int i, input int v, input int g, input bit iv);
      ch_in[i*IW +: IW] = 16'(v);
      ch_gain[i*4 +: 4] = 4'(g);
      ch_inv[i]         = iv;
   endtask

   task automatic do_reset();
      @(negedge clk_49m);
      reset = 1'b0;
      @(negedge clk_49m);
      reset = 1'b1;
   endtask

   // One strobe, bounded wait for sample_valid, then latency/value/pulse-width checks.
   task automatic mix(input string tag, input int exp);
      int lat;
      lat = 99;
      @(negedge clk_49m);
      cen_sample = 1'b1;
      @(negedge clk_49m);
      cen_sample = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk_49m);
         if (sample_valid) begin
            lat = n;
            break;
         end
      end
      check_eq({tag, "_lat"}, lat, LAT);
      check_eq(tag, int'(sound), exp);
      @(negedge clk_49m);
      check_eq({tag, "_pulse"}, int'(sample_valid), 0);
   endtask

   initial begin
      int pulses;
      int got;
      repeat (2) @(negedge clk_49m);
      check_eq("rst_sound", int'(sound), 0);
      check_eq("rst_valid", int'(sample_valid), 0);
      check_eq("rst_clip", int'(clip), 0);
      check_eq("rst_overrun", int'(overrun), 0);
      reset = 1'b1;

`ifdef AUDIO_MIXER_DCRM_EN
      clear_ch();
      set_ch(0, 10000, 8, 1'b0);
      mix("dc0", 10000);
      mix("dc1", 9991);
      mix("dc2", 9982);
      check_eq("dc_clip", int'(clip), 0);
`else
      clear_ch();
      set_ch(0, 1000, 8, 1'b0);
      mix("unity", 1000);
      set_ch(0, 1000, 12, 1'b0);
      mix("gain12", 1500);
      set_ch(0, 1000, 0, 1'b0);
      mix("gain0", 0);
      check_eq("noclip", int'(clip), 0);

      set_ch(0, 30000, 8, 1'b0);
      set_ch(1, 30000, 8, 1'b0);
      mix("satpos", 32767);
      check_eq("satpos_clip", int'(clip), 1);
      set_ch(0, -100, 8, 1'b0);
      set_ch(1, 0, 8, 1'b0);
      mix("neg100", -100);
      check_eq("clip_sticky", int'(clip), 1);

      do_reset();
      check_eq("clip_cleared", int'(clip), 0);
      clear_ch();
      set_ch(0, -32768, 8, 1'b1);
      mix("invmin", 32767);
      check_eq("invmin_clip", int'(clip), 1);
      clear_ch();
      set_ch(2, -200, 8, 1'b1);
      mix("inv2", 200);

      // Second strobe lands mid-accumulation and must be ignored.
      do_reset();
      clear_ch();
      set_ch(0, 500, 8, 1'b0);
      @(negedge clk_49m);
      cen_sample = 1'b1;
      @(negedge clk_49m);
      cen_sample = 1'b0;
      set_ch(0, 7000, 8, 1'b0);
      @(negedge clk_49m);
      cen_sample = 1'b1;
      @(negedge clk_49m);
      cen_sample = 1'b0;
      pulses = 0;
      got = 0;
      repeat (10) begin
         @(negedge clk_49m);
         if (sample_valid) begin
            pulses++;
            got = int'(sound);
         end
      end
      check_eq("ovr_pulses", pulses, 1);
      check_eq("ovr_sound", got, 500);
      check_eq("ovr_flag", int'(overrun), 1);

      do_reset();
      clear_ch();
      set_ch(0, 16384, 8, 1'b0);
      pause = 1'b1;
      for (int k = 0; k < 16; k++) begin
         mix($sformatf("mute_dn%0d", k), (k == 15) ? 0 : (16384 >>> k));
      end
      pause = 1'b0;
      for (int k = 0; k < 16; k++) begin
         mix($sformatf("mute_up%0d", k), (k == 0) ? 0 : (16384 >>> (15 - k)));
      end

      clear_ch();
      set_ch(0, 30000, 8, 1'b0);
      set_ch(1, 30000, 8, 1'b0);
      mix("pre_rst", 32767);
      check_eq("pre_rst_clip", int'(clip), 1);
      set_ch(0, 1000, 8, 1'b0);
      set_ch(1, 2000, 8, 1'b0);
      @(negedge clk_49m);
      cen_sample = 1'b1;
      @(negedge clk_49m);
      cen_sample = 1'b0;
      repeat (2) @(negedge clk_49m);
      reset = 1'b0;
      #1;
      check_eq("mid_rst_sound", int'(sound), 0);
      check_eq("mid_rst_valid", int'(sample_valid), 0);
      check_eq("mid_rst_clip", int'(clip), 0);
      check_eq("mid_rst_overrun", int'(overrun), 0);
      @(negedge clk_49m);
      reset = 1'b1;
      pulses = 0;
      repeat (8) begin
         @(negedge clk_49m);
         if (sample_valid) pulses++;
      end
      check_eq("aborted_pulses", pulses, 0);
      mix("post_rst", 3000);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/audio_mixer_nch.md
Name: audio_mixer_nch

Overview:
- Parametrised N-channel signed audio mixer for arcade PCB models; replaces the ad-hoc per-chip gain, inversion and sum logic in each core's sound section.
- Per channel: sample, 4-bit gain, optional phase inversion.
- Channels are summed time-multiplexed, one channel per clock, into a wide accumulator, then saturated to the output width.
- A pause-driven soft mute ramps the output down and back up.

Parameters:
- NCH, 4, number of input channels (2..8)
- IW, 16, input sample width (signed)
- OW, 16, output sample width (signed)
- ACCW, 24, accumulator width; must be at least IW+4+clog2(NCH)

Ports:
- clk_49m  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cen_sample  in  1  output-rate strobe, one clk_49m cycle wide
- ch_in  in  NCH*IW  packed signed samples; channel i at [i*IW +: IW]
- ch_gain  in  NCH*4  unsigned gain per channel, Q1.3 format (8 = unity, 15 = 1.875)
- ch_inv  in  NCH  1 = negate that channel's term
- pause  in  1  request soft mute
- sound  out  OW  signed mixed output, registered
- sample_valid  out  1  one-cycle pulse when sound updates
- clip  out  1  sticky: saturation occurred
- overrun  out  1  sticky: cen_sample arrived while busy

Behaviour:
- Reset (async, reset=0): sound=0, sample_valid=0, clip=0, overrun=0, acc=0, idx=0, mute_sh=0, state=IDLE.
- IDLE, cen_sample=1: snapshot ch_in, ch_gain and ch_inv into holding registers; acc<=0; idx<=0; go to ACCUM.
- ACCUM, one channel per cycle:
  - term = sign-extend(in[idx] * {1'b0,gain[idx]}) >>> 3, arithmetic shift, computed at IW+5 bits.
  - If inv[idx]=1, term is negated at IW+5 bits, so -2^(IW-1) negates exactly.
  - acc <= acc + sign-extend(term to ACCW).
  - After idx=NCH-1, go to SAT.
- SAT:
  - Clamp acc to [-2^(OW-1), 2^(OW-1)-1]; set clip=1 if clamping occurred.
  - Apply mute: value >>> mute_sh; when mute_sh >= OW-1 the result is forced to 0.
  - Register the result to sound; pulse sample_valid; return to IDLE.
- Latency: sound and sample_valid appear NCH+1 cycles after the cen_sample cycle.
- Mute ramp, evaluated once per SAT pass:
  - pause=1 and mute_sh<OW-1: mute_sh+1.
  - pause=0 and mute_sh>0: mute_sh-1.
  - The ramp uses the mute_sh value from before the update, so the first muted sample is unattenuated.
- cen_sample while not in IDLE: ignored, no effect on the in-flight mix; overrun<=1.
- clip and overrun are cleared only by reset.
- Inputs may change freely after the snapshot cycle.

Optional Feature:
- Macro AUDIO_MIXER_DCRM_EN.
- Defined: the saturated, muted value passes through a first-order DC blocker before sound: y = x - x_prev + y_prev - (y_prev >>> 10), computed at OW+2 bits and saturated to OW. DC-blocker state resets to 0. Adds one cycle, so latency is NCH+2 and sample_valid moves with it.
- Undefined: no blocker; latency NCH+1.

Decomposition:
- audio_mixer_pkg holds:
  - state enum {IDLE, ACCUM, SAT}
  - GAIN_W=4, GAIN_FRAC=3, DCRM_K=10
  - function sat_signed(value, width)
- Sub-module audio_mixer_dcrm (OW parameter), instantiated only under AUDIO_MIXER_DCRM_EN.

Test Plan (NCH=4, IW=OW=16, macro off unless stated):
- ch0=1000, gain0=8, other channels 0 → sound=1000, sample_valid exactly 5 cycles after the strobe; gain0=12 → 1500; gain0=0 → 0.
- ch0=ch1=30000, both gain 8 → sound=32767, clip=1; next mix ch0=-100 → sound=-100, clip stays 1.
- ch0=-32768, inv0=1, gain 8 → sound=32767, clip=1; ch2=-200, inv2=1 → sound=+200.
- Strobe, then a second strobe 2 cycles later → single sample_valid pulse, overrun=1, sound from the first snapshot.
- Constant ch0=16384, gain 8, pause=1 → sounds 16384, 8192, 4096, …, 0 by the 16th sample; pause=0 → ramps back to 16384.
- reset=0 asserted in the ACCUM cycle after idx=1 → sound=0, flags 0, IDLE immediately; next strobe yields the correct sum. Macro on: constant input 10000 → output decays toward 0 and the first sample_valid arrives 6 cycles after the strobe.
